// File: rtl/fht_frame_loader_if.sv
// Sample stream and banked RAM write bus of the FHT frame loader.
// The slave side is the loader; the master side is the source/RAM environment.
interface fht_frame_loader_if #(
    parameter int D_BIT = 22,
    parameter int A_BIT = 8,
    parameter int BANKS = 4
);
    logic             iVALID;
    logic             oREADY;
    logic [D_BIT-1:0] iDATA;
    logic [BANKS-1:0] oWE;
    logic [A_BIT-1:0] oADDR_WR;
    logic [D_BIT-1:0] oDATA;

    modport master (
        output iVALID, iDATA,
        input  oREADY, oWE, oADDR_WR, oDATA
    );

    modport slave (
        input  iVALID, iDATA,
        output oREADY, oWE, oADDR_WR, oDATA
    );
endinterface

// File: rtl/fht_frame_loader.sv
// Frame loader: spreads a valid/ready sample stream round-robin over the
// banked write port of fht_top, in natural or bit-reversed row order, with
// optional ADC fixed-point expansion; then starts the core and reports
// frame completion.
module fht_frame_loader #(
    parameter int ADC_WIDTH = 16,
    parameter int D_BIT     = 22,
    parameter int A_BIT     = 8,
    parameter int BANKS     = 4
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iARM,
    input  logic iMODE,
    input  logic iSRC,
    input  logic iABORT,
    output logic oSTART,
    input  logic iCORE_RDY,
    output logic oBUSY,
    output logic oDONE,
    fht_frame_loader_if.slave s_bus
);
    localparam int BANK_BIT = $clog2(BANKS);
    localparam int CNT_W    = A_BIT + BANK_BIT;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mode;
    logic                r_src;
    logic [1:0]          r_wait;
    logic                r_start;
    logic [BANKS-1:0]    r_we;
    logic [A_BIT-1:0]    r_addr;
    logic [D_BIT-1:0]    r_data;

    logic                w_ready;
    logic                w_accept;
    logic                w_blank_done;
    logic [BANK_BIT-1:0] w_bank;
    logic [A_BIT-1:0]    w_row;

    function automatic logic [A_BIT-1:0] bit_reverse(input logic [A_BIT-1:0] row);
        logic [A_BIT-1:0] v;
        for (int i = 0; i < A_BIT; i++) begin
            v[i] = row[A_BIT-1-i];
        end
        return v;
    endfunction

    // ADC samples are left-aligned so the sign bit lands on the datapath MSB.
    function automatic logic [D_BIT-1:0] expand_sample(input logic [D_BIT-1:0] d,
                                                       input logic src);
        logic [D_BIT-1:0] v;
        if (src) begin
            v = d;
        end else begin
            v = '0;
            v[ADC_WIDTH-1:0] = d[ADC_WIDTH-1:0];
            v = v << (D_BIT - ADC_WIDTH);
        end
        return v;
    endfunction

    // Abort gates ready so an abort-cycle sample is never taken.
    assign w_ready      = (r_state == S_LOAD) && !iABORT;
    assign w_accept     = s_bus.iVALID && w_ready;
    assign w_bank       = r_cnt[BANK_BIT-1:0];
    assign w_row        = r_cnt[CNT_W-1:BANK_BIT];
    assign w_blank_done = (r_wait == 2'd2);

    assign s_bus.oREADY   = w_ready;
    assign s_bus.oWE      = r_we;
    assign s_bus.oADDR_WR = r_addr;
    assign s_bus.oDATA    = r_data;
    assign oSTART         = r_start;
    assign oBUSY          = (r_state != S_IDLE);
    assign oDONE          = (r_state == S_DONE);

    // State register.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iARM) w_next = S_LOAD;
            S_LOAD:  if (w_accept && (r_cnt == CNT_LAST)) w_next = S_FLUSH;
            S_FLUSH: w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (w_blank_done && iCORE_RDY) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (iABORT) begin
            w_next = S_IDLE;
        end
    end

    // Sample counter, latched frame options, WAIT blanking and start pulse.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_src   <= 1'b0;
            r_wait  <= 2'd0;
            r_start <= 1'b0;
        end else begin
            if (iABORT) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == S_IDLE) && iARM && !iABORT) begin
                r_mode <= iMODE;
                r_src  <= iSRC;
            end
            if (r_state == S_WAIT) begin
                if (!w_blank_done) begin
                    r_wait <= r_wait + 2'd1;
                end
            end else begin
                r_wait <= 2'd0;
            end
            r_start <= (r_state == S_START) && !iABORT;
        end
    end

    // Registered bank write port; address and data hold between writes.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_we   <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_accept ? (BANKS'(1) << w_bank) : '0;
            if (w_accept) begin
                r_addr <= r_mode ? bit_reverse(w_row) : w_row;
                r_data <= expand_sample(s_bus.iDATA, r_src);
            end
        end
    end
endmodule

// File: tb/tb_fht_frame_loader.sv
// Scoreboard bench for fht_frame_loader with 4 banks of 8 rows (32 samples).
module tb_fht_frame_loader;
    localparam int ADC_WIDTH = 16;
    localparam int D_BIT     = 22;
    localparam int A_BIT     = 3;
    localparam int BANKS     = 4;

    logic iCLK = 1'b0;
    logic iRESET, iARM, iMODE, iSRC, iABORT, iCORE_RDY;
    logic oSTART, oBUSY, oDONE;

    fht_frame_loader_if #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BANKS(BANKS)) bus();

    fht_frame_loader #(
        .ADC_WIDTH(ADC_WIDTH), .D_BIT(D_BIT), .A_BIT(A_BIT), .BANKS(BANKS)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iARM(iARM), .iMODE(iMODE), .iSRC(iSRC),
        .iABORT(iABORT), .oSTART(oSTART), .iCORE_RDY(iCORE_RDY), .oBUSY(oBUSY),
        .oDONE(oDONE), .s_bus(bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [BANKS-1:0] we;
        logic [A_BIT-1:0] addr;
        logic [D_BIT-1:0] data;
    } wr_t;

    wr_t              sb[$];
    logic [A_BIT-1:0] addr_log[$];
    logic [A_BIT-1:0] rev_tab[8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    logic [31:0]      seen;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int wr_count = 0;
    int start_cnt = 0;
    int done_cnt = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    // Write-port monitor: every write is popped from the scoreboard.
    always @(negedge iCLK) begin
        wr_t exp;
        if (oSTART === 1'b1) start_cnt++;
        if (oDONE === 1'b1) done_cnt++;
        if (bus.oWE !== '0) begin
            wr_count++;
            last_we_cyc = cyc;
            addr_log.push_back(bus.oADDR_WR);
            for (int b = 0; b < BANKS; b++)
                if (bus.oWE[b] === 1'b1) seen[int'(bus.oADDR_WR) * BANKS + b] = 1'b1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got we=%b addr=%0d data=%h, expected no write",
                         bus.oWE, bus.oADDR_WR, bus.oDATA);
            end else begin
                exp = sb.pop_front();
                if ({bus.oWE, bus.oADDR_WR, bus.oDATA} !== exp) begin
                    errors++;
                    $display("FAIL write got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                             bus.oWE, bus.oADDR_WR, bus.oDATA, exp.we, exp.addr, exp.data);
                end
            end
        end
    end

    function automatic wr_t model(int k, logic [D_BIT-1:0] d, logic mode, logic src);
        wr_t w;
        int  row;
        row    = k / BANKS;
        w.we   = BANKS'(1) << (k % BANKS);
        w.addr = mode ? rev_tab[row] : A_BIT'(row);
        w.data = src ? d : {d[ADC_WIDTH-1:0], {(D_BIT-ADC_WIDTH){1'b0}}};
        return w;
    endfunction

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic arm(input logic mode, input logic src);
        iARM = 1'b1; iMODE = mode; iSRC = src;
        step();
        iARM = 1'b0; iMODE = ~mode; iSRC = ~src;
    endtask

    // kind 0: data k (sample 5 is -1); kind 1: random full-width data.
    task automatic send(input int k0, input int n, input logic mode, input logic src,
                        input logic gap, input int kind);
        logic [D_BIT-1:0] d;
        for (int k = k0; k < k0 + n; k++) begin
            d = (kind == 1) ? D_BIT'($urandom) : ((k == 5) ? 22'h3FFFFF : D_BIT'(k));
            bus.iDATA = d; bus.iVALID = 1'b1;
            @(negedge iCLK);
            checks++;
            if (bus.oREADY !== 1'b1) begin
                errors++;
                $display("FAIL ready_in_load sample %0d got %b expected 1", k, bus.oREADY);
            end
            sb.push_back(model(k, d, mode, src));
            step();
            if (gap) begin
                bus.iVALID = 1'b0; bus.iDATA = ~d;
                step();
            end
        end
        bus.iVALID = 1'b0;
    endtask

    task automatic wait_start(output int s);
        bit got = 0;
        s = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge iCLK);
            if (oSTART === 1'b1) begin got = 1; s = cyc; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL start_timeout got no oSTART expected one within 40 cycles");
        end
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge iCLK);
            if (oDONE === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout got no oDONE expected one within 40 cycles");
        end
    endtask

    task automatic test_reset();
        iARM = 0; iMODE = 0; iSRC = 0; iABORT = 0; iCORE_RDY = 0;
        bus.iVALID = 0; bus.iDATA = '0;
        iRESET = 1'b1;
        #2 iRESET = 1'b0;
        #1;
        checks++;
        if ({bus.oWE, bus.oADDR_WR, bus.oDATA, bus.oREADY, oSTART, oBUSY, oDONE} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b addr=%0d data=%h rdy=%b st=%b busy=%b done=%b expected all 0",
                     bus.oWE, bus.oADDR_WR, bus.oDATA, bus.oREADY, oSTART, oBUSY, oDONE);
        end
        step(); step();
        iRESET = 1'b1;
        step();
    endtask

    task automatic test_idle_ignored();
        wr_count = 0;
        bus.iVALID = 1'b1; bus.iDATA = 22'h12345;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            checks++;
            if (bus.oREADY !== 1'b0 || oBUSY !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid got rdy=%b busy=%b expected 0 0", bus.oREADY, oBUSY);
            end
            step();
        end
        bus.iVALID = 1'b0;
        step();
        checks++;
        if (wr_count != 0) begin
            errors++;
            $display("FAIL idle_writes got %0d expected 0", wr_count);
        end
    endtask

    task automatic test_natural_adc();
        int s;
        wr_count = 0; start_cnt = 0; done_cnt = 0;
        iCORE_RDY = 1'b1;
        arm(1'b0, 1'b0);
        send(0, 32, 1'b0, 1'b0, 1'b0, 0);
        @(negedge iCLK);
        checks++;
        if (bus.oREADY !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop got %b expected 0", bus.oREADY);
        end
        wait_start(s);
        checks++;
        if (s - last_we_cyc != 2) begin
            errors++;
            $display("FAIL start_latency got %0d expected 2", s - last_we_cyc);
        end
        checks++;
        if (oDONE !== 1'b0) begin
            errors++;
            $display("FAIL done_early wait1 got %b expected 0", oDONE);
        end
        for (int i = 2; i <= 3; i++) begin
            @(negedge iCLK);
            checks++;
            if (oDONE !== 1'b0) begin
                errors++;
                $display("FAIL done_early wait%0d got %b expected 0", i, oDONE);
            end
        end
        @(negedge iCLK);
        checks++;
        if (oDONE !== 1'b1 || oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b expected 1 1", oDONE, oBUSY);
        end
        @(negedge iCLK);
        checks++;
        if (oDONE !== 1'b0 || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL done_to_idle got done=%b busy=%b expected 0 0", oDONE, oBUSY);
        end
        iCORE_RDY = 1'b0;
        step();
        checks++;
        if (wr_count != 32 || start_cnt != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL natural_counts got wr=%0d st=%0d dn=%0d expected 32 1 1",
                     wr_count, start_cnt, done_cnt);
        end
    endtask

    task automatic test_bitrev_pass();
        int s;
        addr_log.delete();
        done_cnt = 0;
        iCORE_RDY = 1'b0;
        arm(1'b1, 1'b1);
        send(0, 32, 1'b1, 1'b1, 1'b0, 1);
        wait_start(s);
        checks++;
        if (addr_log.size() != 32 || addr_log[4] !== 3'd4 || addr_log[12] !== 3'd6 ||
            addr_log[24] !== 3'd3) begin
            errors++;
            $display("FAIL bitrev_rows got n=%0d r1=%0d r3=%0d r6=%0d expected 32 4 6 3",
                     addr_log.size(), addr_log[4], addr_log[12], addr_log[24]);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge iCLK);
            checks++;
            if (oDONE !== 1'b0) begin
                errors++;
                $display("FAIL done_while_low cycle %0d got %b expected 0", i, oDONE);
            end
        end
        step();
        iCORE_RDY = 1'b1;
        @(negedge iCLK);
        checks++;
        if (oDONE !== 1'b0) begin
            errors++;
            $display("FAIL done_on_rise got %b expected 0", oDONE);
        end
        step();
        iARM = 1'b1; iMODE = 1'b0; iSRC = 1'b0;
        @(negedge iCLK);
        checks++;
        if (oDONE !== 1'b1) begin
            errors++;
            $display("FAIL done_after_rise got %b expected 1", oDONE);
        end
        step();
        iARM = 1'b0; iCORE_RDY = 1'b0;
        @(negedge iCLK);
        checks++;
        if (oBUSY !== 1'b0 || oDONE !== 1'b0) begin
            errors++;
            $display("FAIL arm_on_done got busy=%b done=%b expected 0 0", oBUSY, oDONE);
        end
        step();
    endtask

    task automatic test_stall();
        int c0;
        wr_count = 0; start_cnt = 0; seen = '0;
        arm(1'b0, 1'b0);
        iARM = 1'b1; iMODE = 1'b1; iSRC = 1'b1;
        step();
        iARM = 1'b0;
        c0 = cyc;
        send(0, 32, 1'b0, 1'b0, 1'b1, 0);
        checks++;
        if (wr_count != 32 || cyc - c0 != 64) begin
            errors++;
            $display("FAIL stall_writes got wr=%0d cycles=%0d expected 32 64", wr_count, cyc - c0);
        end
        checks++;
        if (seen !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stall_coverage got %h expected ffffffff", seen);
        end
        iCORE_RDY = 1'b1;
        wait_done();
        iCORE_RDY = 1'b0;
        step(); step();
        checks++;
        if (start_cnt != 1) begin
            errors++;
            $display("FAIL stall_starts got %0d expected 1", start_cnt);
        end
    endtask

    task automatic test_abort_reset();
        int s;
        start_cnt = 0; wr_count = 0; done_cnt = 0;
        iCORE_RDY = 1'b0;
        arm(1'b0, 1'b0);
        send(0, 13, 1'b0, 1'b0, 1'b0, 0);
        bus.iVALID = 1'b1; bus.iDATA = 22'h2AAAA; iABORT = 1'b1; iARM = 1'b1;
        step();
        iABORT = 1'b0; iARM = 1'b0; bus.iVALID = 1'b0;
        @(negedge iCLK);
        checks++;
        if (oBUSY !== 1'b0 || bus.oWE !== '0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b we=%b expected 0 0", oBUSY, bus.oWE);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (start_cnt != 0 || wr_count != 13) begin
            errors++;
            $display("FAIL abort_no_start got st=%0d wr=%0d expected 0 13", start_cnt, wr_count);
        end
        arm(1'b0, 1'b0);
        send(0, 1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge iCLK);
        checks++;
        if (bus.oWE !== 4'b0001 || bus.oADDR_WR !== 3'd0) begin
            errors++;
            $display("FAIL rearm_first got we=%b addr=%0d expected 0001 0", bus.oWE, bus.oADDR_WR);
        end
        step();
        send(1, 31, 1'b0, 1'b0, 1'b0, 0);
        wait_start(s);
        step();
        iRESET = 1'b0;
        #1;
        checks++;
        if ({bus.oWE, bus.oADDR_WR, bus.oDATA, bus.oREADY, oSTART, oBUSY, oDONE} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait got we=%b addr=%0d data=%h rdy=%b st=%b busy=%b done=%b expected all 0",
                     bus.oWE, bus.oADDR_WR, bus.oDATA, bus.oREADY, oSTART, oBUSY, oDONE);
        end
        step();
        iRESET = 1'b1;
        iCORE_RDY = 1'b1;
        for (int i = 0; i < 6; i++) step();
        iCORE_RDY = 1'b0;
        checks++;
        if (done_cnt != 0 || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done got dn=%0d busy=%b expected 0 0", done_cnt, oBUSY);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignored();
        test_natural_adc();
        test_bitrev_pass();
        test_stall();
        test_abort_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
